// File: rtl/axi_lite_ram_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_ram_pkg
//   Shared definitions for the AXI4-Lite RAM target:
//     - AXI response codes
//     - read FSM state encoding
//     - clog2 / idx_width helpers used to size the word index
// -----------------------------------------------------------------------------
package axi_lite_ram_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Read FSM encoding; ST_WAIT is only reachable with AXI_LITE_RAM_WAIT_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Ceiling log2 for elaboration-time sizing
    function automatic int unsigned clog2(input longint unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Word-index width for a byte window of mem_size; never narrower than 1
    function automatic int unsigned idx_width(input int unsigned mem_size);
        if ((mem_size / 4) <= 1) begin
            return 1;
        end
        return clog2(longint'(mem_size / 4));
    endfunction

endpackage

// File: rtl/axi_lite_ram_mem.sv
// -----------------------------------------------------------------------------
// axi_lite_ram_mem
//   Single-port, byte-enabled DEPTH x 32 RAM with a registered read port.
//   One access per cycle: the caller guarantees wr_en_i and rd_en_i are never
//   asserted together. rdata_o only changes on a cycle with rd_en_i.
//
// Ports
//   clk_i    clock
//   rst_i    async active-high reset (read-data register only)
//   wr_en_i  write enable (applies wstrb_i per byte)
//   wstrb_i  byte strobes
//   rd_en_i  read enable, loads rdata_o from addr_i
//   addr_i   word index
//   wdata_i  write data
//   rdata_o  registered read data
// -----------------------------------------------------------------------------
module axi_lite_ram_mem
    import axi_lite_ram_pkg::*;
#(
    parameter int unsigned DEPTH = 16384,
    parameter int unsigned IDX_W = 14
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [3:0]       wstrb_i,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // NOTE: the array has no reset branch; resetting a RAM would force it into
    // flops, and stored contents are meant to survive rst_i.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // NOTE: non-blocking assignment for all clocked state, so every flop
    // samples the values from before the edge regardless of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= 32'h0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_ram.sv
// -----------------------------------------------------------------------------
// axi_lite_ram
//   AXI4-Lite target RAM terminating the data-port AXI initiator. No IDs, no
//   bursts. Independent 1-deep AW and W hold registers; a write commits once
//   both are held and the B channel is free. Writes take priority over reads
//   on the single RAM port by withholding arready while a commit is pending.
//   Addresses outside [MEM_BASE, MEM_BASE+MEM_SIZE) answer DECERR.
//
// Build option
//   AXI_LITE_RAM_WAIT_EN  when defined, reads spend READ_WAIT extra cycles in
//                         a WAIT state before rvalid (READ_WAIT=0 -> no WAIT).
//
// Ports
//   clk_i, rst_i                  clock, async active-high reset
//   axi_aw{valid,addr}_i/ready_o  write address channel
//   axi_w{valid,data,strb}_i/ready_o  write data channel
//   axi_b{valid,resp}_o/ready_i   write response channel
//   axi_ar{valid,addr}_i/ready_o  read address channel
//   axi_r{valid,data,resp}_o/ready_i  read data channel
// -----------------------------------------------------------------------------
module axi_lite_ram
    import axi_lite_ram_pkg::*;
#(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int unsigned MEM_SIZE  = 64 * 1024,
    parameter int unsigned READ_WAIT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        axi_awvalid_i,
    input  logic [31:0] axi_awaddr_i,
    output logic        axi_awready_o,

    input  logic        axi_wvalid_i,
    input  logic [31:0] axi_wdata_i,
    input  logic [3:0]  axi_wstrb_i,
    output logic        axi_wready_o,

    output logic        axi_bvalid_o,
    output logic [1:0]  axi_bresp_o,
    input  logic        axi_bready_i,

    input  logic        axi_arvalid_i,
    input  logic [31:0] axi_araddr_i,
    output logic        axi_arready_o,

    output logic        axi_rvalid_o,
    output logic [31:0] axi_rdata_o,
    output logic [1:0]  axi_rresp_o,
    input  logic        axi_rready_i
);

    localparam int unsigned DEPTH = MEM_SIZE / 4;
    localparam int unsigned IDX_W = idx_width(MEM_SIZE);

    // ---------------------------------------------------------------- decode
    // Offset-based compare avoids overflow of MEM_BASE+MEM_SIZE at the top of
    // the address space.
    logic [31:0] aw_off;
    logic [31:0] ar_off;
    logic        aw_hit;
    logic        ar_hit;

    assign aw_off = axi_awaddr_i - MEM_BASE;
    assign ar_off = axi_araddr_i - MEM_BASE;
    assign aw_hit = (axi_awaddr_i >= MEM_BASE) && (aw_off < MEM_SIZE);
    assign ar_hit = (axi_araddr_i >= MEM_BASE) && (ar_off < MEM_SIZE);

    // Byte-lane and above-window offset bits carry no information once the
    // hit flag and word index are extracted.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{aw_off[31:IDX_W+2], aw_off[1:0],
                                ar_off[31:IDX_W+2], ar_off[1:0]};

    // ------------------------------------------------------------ write path
    logic             aw_held_q;
    logic             aw_hit_q;
    logic [IDX_W-1:0] aw_idx_q;
    logic             w_held_q;
    logic [31:0]      w_data_q;
    logic [3:0]       w_strb_q;
    logic             bvalid_q;
    logic [1:0]       bresp_q;

    logic aw_fire;
    logic w_fire;
    logic commit;

    assign aw_fire = axi_awvalid_i && !aw_held_q;
    assign w_fire  = axi_wvalid_i && !w_held_q;
    // A stalled B response holds off the next commit; when bready arrives the
    // old response retires and the new one loads on the same edge.
    assign commit  = aw_held_q && w_held_q && (!bvalid_q || axi_bready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_held_q <= 1'b0;
            aw_hit_q  <= 1'b0;
            aw_idx_q  <= '0;
        end else if (aw_fire) begin
            aw_held_q <= 1'b1;
            aw_hit_q  <= aw_hit;
            aw_idx_q  <= aw_off[IDX_W+1:2];
        end else if (commit) begin
            aw_held_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_held_q <= 1'b0;
            w_data_q <= 32'h0;
            w_strb_q <= 4'h0;
        end else if (w_fire) begin
            w_held_q <= 1'b1;
            w_data_q <= axi_wdata_i;
            w_strb_q <= axi_wstrb_i;
        end else if (commit) begin
            w_held_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= aw_hit_q ? RESP_OKAY : RESP_DECERR;
        end else if (axi_bready_i) begin
            bvalid_q <= 1'b0;
        end
    end

    assign axi_awready_o = !aw_held_q;
    assign axi_wready_o  = !w_held_q;
    assign axi_bvalid_o  = bvalid_q;
    assign axi_bresp_o   = bresp_q;

    // -------------------------------------------------------------- read FSM
    logic [1:0] state_q;
    logic       rd_hit_q;
    logic [1:0] rresp_q;
    logic       arready;
    logic       ar_fire;

`ifdef AXI_LITE_RAM_WAIT_EN
    localparam int unsigned WAIT_CNT_W = (READ_WAIT == 0) ? 1 : clog2(longint'(READ_WAIT) + 1);
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
`endif

    // Blocking on both holds (not on commit itself) keeps arready a pure
    // function of registers and guarantees the RAM port is free for the write.
    assign arready = (state_q == ST_IDLE) && !(aw_held_q && w_held_q);
    assign ar_fire = axi_arvalid_i && arready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rd_hit_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
`ifdef AXI_LITE_RAM_WAIT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ar_fire) begin
                        rd_hit_q <= ar_hit;
                        rresp_q  <= ar_hit ? RESP_OKAY : RESP_DECERR;
`ifdef AXI_LITE_RAM_WAIT_EN
                        if (READ_WAIT == 0) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q    <= ST_WAIT;
                            wait_cnt_q <= WAIT_CNT_W'(READ_WAIT);
                        end
`else
                        state_q <= ST_RESP;
`endif
                    end
                end
`ifdef AXI_LITE_RAM_WAIT_EN
                ST_WAIT: begin
                    // Leave on the decrement that reaches zero
                    wait_cnt_q <= wait_cnt_q - 1'b1;
                    if (wait_cnt_q == WAIT_CNT_W'(1)) begin
                        state_q <= ST_RESP;
                    end
                end
`endif
                ST_RESP: begin
                    if (axi_rready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ RAM port
    logic [31:0]      mem_rdata;
    logic [IDX_W-1:0] mem_addr;

    // Commit and AR acceptance are mutually exclusive, so a plain mux suffices
    assign mem_addr = commit ? aw_idx_q : ar_off[IDX_W+1:2];

    axi_lite_ram_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en_i (commit && aw_hit_q),
        .wstrb_i (w_strb_q),
        .rd_en_i (ar_fire && ar_hit),
        .addr_i  (mem_addr),
        .wdata_i (w_data_q),
        .rdata_o (mem_rdata)
    );

    // A missed read never touches the RAM, so its stale register is masked
    assign axi_arready_o = arready;
    assign axi_rvalid_o  = (state_q == ST_RESP);
    assign axi_rdata_o   = rd_hit_q ? mem_rdata : 32'h0;
    assign axi_rresp_o   = rresp_q;

endmodule

// File: tb/tb_axi_lite_ram.sv
module tb_axi_lite_ram;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int unsigned SIZE = 64 * 1024;
    localparam int unsigned RW   = 2;
`ifdef AXI_LITE_RAM_WAIT_EN
    localparam int RD_LAT = (RW == 0) ? 1 : RW + 1;
`else
    localparam int RD_LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic [1:0]  exp_b [$];
    r_exp_t      exp_r [$];
    logic [31:0] model_mem [int unsigned];

    axi_lite_ram #(
        .MEM_BASE  (BASE),
        .MEM_SIZE  (SIZE),
        .READ_WAIT (RW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .axi_awvalid_i (awvalid),
        .axi_awaddr_i  (awaddr),
        .axi_awready_o (awready),
        .axi_wvalid_i  (wvalid),
        .axi_wdata_i   (wdata),
        .axi_wstrb_i   (wstrb),
        .axi_wready_o  (wready),
        .axi_bvalid_o  (bvalid),
        .axi_bresp_o   (bresp),
        .axi_bready_i  (bready),
        .axi_arvalid_i (arvalid),
        .axi_araddr_i  (araddr),
        .axi_arready_o (arready),
        .axi_rvalid_o  (rvalid),
        .axi_rdata_o   (rdata),
        .axi_rresp_o   (rresp),
        .axi_rready_i  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < SIZE);
    endfunction

    // Reference model: byte-merge into the word on every write that hits
    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int unsigned idx;
        logic [31:0] w;
        if (!in_win(a) || s == 4'h0) return;
        idx = (a - BASE) >> 2;
        w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        model_mem[idx] = w;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned idx;
        if (!in_win(a)) return 32'h0;
        idx = (a - BASE) >> 2;
        return model_mem.exists(idx) ? model_mem[idx] : 32'hxxxx_xxxx;
    endfunction

    // Scoreboard: compare each response as it is handshaked
    always @(negedge clk) begin
        if (!rst) begin
            if (bvalid && bready) begin
                if (exp_b.size() == 0) check("b_unexpected", 32'd1, 32'd0);
                else check("bresp", 32'(bresp), 32'(exp_b.pop_front()));
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    check("r_unexpected", 32'd1, 32'd0);
                end else begin
                    r_exp_t e;
                    e = exp_r.pop_front();
                    check("rdata", rdata, e.data);
                    check("rresp", 32'(rresp), 32'(e.resp));
                end
            end
        end
    end

    // Drive AW and W with independent start delays; returns once both are held
    task automatic send_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int aw_dly, input int w_dly, output int early_b);
        bit aw_done = 0;
        bit w_done  = 0;
        int cyc     = 0;
        early_b = 0;
        exp_b.push_back(in_win(a) ? 2'b00 : 2'b11);
        model_write(a, d, s);
        awaddr = a;
        wdata  = d;
        wstrb  = s;
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            if (bvalid) early_b++;
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            tick();
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) check("write_handshake_timeout", 32'd0, 32'd1);
    endtask

    // Cycles from the handshake cycle to bvalid; ends one edge after bvalid seen
    task automatic wait_b(output int lat);
        lat = 1;
        while (lat < 50) begin
            @(negedge clk);
            if (bvalid) break;
            tick();
            lat++;
        end
        if (lat >= 50) check("b_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] seen);
        r_exp_t e;
        bit done = 0;
        int cyc  = 0;
        e.data = model_read(a);
        e.resp = in_win(a) ? 2'b00 : 2'b11;
        exp_r.push_back(e);
        araddr  = a;
        arvalid = 1'b1;
        while (!done && cyc < 50) begin
            @(negedge clk);
            done = arvalid && arready;
            tick();
            cyc++;
        end
        arvalid = 1'b0;
        lat  = 1;
        seen = 32'h0;
        if (!done) begin
            check("ar_timeout", 32'd0, 32'd1);
            return;
        end
        while (lat < 50) begin
            @(negedge clk);
            check("arready_busy", 32'(arready), 32'd0);
            if (rvalid) break;
            tick();
            lat++;
        end
        seen = rdata;
        tick();
    endtask

    initial begin
        int lat;
        int early;
        logic [31:0] seen;

        rst = 1'b1;
        {awvalid, wvalid, arvalid} = 3'b000;
        {bready, rready} = 2'b11;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;

        // Reset state
        @(negedge clk);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bresp",  32'(bresp),  32'd0);
        check("rst_rresp",  32'(rresp),  32'd0);
        check("rst_rdata",  rdata,       32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {29'd0, awready, wready, arready}, 32'd7);
        tick();

        // Seed the word sampled later by the out-of-window test
        send_write(32'h8000_0000, 32'hA5A5_5A5A, 4'hF, 0, 0, early);
        wait_b(lat);

        // Write then read, AW and W together
        send_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, early);
        wait_b(lat);
        check("b_latency", 32'(lat), 32'd2);
        do_read(32'h8000_0010, lat, seen);
        check("r_latency", 32'(lat), 32'(RD_LAT));
        check("r_data_1", seen, 32'hDEAD_BEEF);

        // W first, AW three cycles later, partial strobes
        send_write(32'h8000_0010, 32'h1122_3344, 4'b0101, 3, 0, early);
        check("no_early_b", 32'(early), 32'd0);
        wait_b(lat);
        check("b_latency_split", 32'(lat), 32'd2);
        do_read(32'h8000_0010, lat, seen);
        check("r_data_strobe", seen, 32'hDE22_BE44);

        // Zero strobes: OKAY, nothing written
        send_write(32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, 1, early);
        wait_b(lat);
        do_read(32'h8000_0010, lat, seen);
        check("r_data_nostrb", seen, 32'hDE22_BE44);

        // Out of window on both channels
        send_write(32'h7FFF_FFFC, 32'h0BAD_0BAD, 4'hF, 0, 0, early);
        wait_b(lat);
        do_read(32'h9000_0000, lat, seen);
        check("r_data_miss", seen, 32'h0);
        do_read(32'h8001_0000, lat, seen);
        check("r_data_miss_top", seen, 32'h0);
        do_read(32'h8000_0000, lat, seen);
        check("r_data_unchanged", seen, 32'hA5A5_5A5A);

        // B backpressure with a second write held behind it
        bready = 1'b0;
        send_write(32'h8000_0020, 32'h0102_0304, 4'hF, 0, 0, early);
        wait_b(lat);
        send_write(32'h8000_0024, 32'h0A0B_0C0D, 4'hF, 0, 0, early);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_bvalid",  32'(bvalid),  32'd1);
            check("bp_bresp",   32'(bresp),   32'd0);
            check("bp_awready", 32'(awready), 32'd0);
            check("bp_wready",  32'(wready),  32'd0);
            check("bp_arready", 32'(arready), 32'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_commit_ready", {30'd0, awready, wready}, 32'd3);
        check("bp_second_b", 32'(bvalid), 32'd1);
        tick();

        // R backpressure; a write commit during the stall must not disturb rdata
        rready = 1'b0;
        do_read(32'h8000_0020, lat, seen);
        check("r_latency_bp", 32'(lat), 32'(RD_LAT));
        send_write(32'h8000_0020, 32'hFFFF_0000, 4'hF, 0, 0, early);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rbp_rvalid", 32'(rvalid), 32'd1);
            check("rbp_rdata",  rdata,       32'h0102_0304);
            tick();
        end
        rready = 1'b1;
        tick();
        do_read(32'h8000_0020, lat, seen);
        check("r_data_after_stall", seen, 32'hFFFF_0000);
        do_read(32'h8000_0024, lat, seen);
        check("r_data_second", seen, 32'h0A0B_0C0D);

        // Write holds full while AR valid: write commits first, AR next cycle
        exp_b.push_back(2'b00);
        model_write(32'h8000_0030, 32'hCAFE_F00D, 4'hF);
        awaddr = 32'h8000_0030; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check("cf_aw_w_accept", {30'd0, awready, wready}, 32'd3);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h8000_0030; arvalid = 1'b1;
        @(negedge clk);
        check("cf_ar_blocked", 32'(arready), 32'd0);
        tick();
        do_read(32'h8000_0030, lat, seen);
        check("cf_new_data", seen, 32'hCAFE_F00D);

        // Reset with both responses outstanding
        bready = 1'b0;
        rready = 1'b0;
        send_write(32'h8000_0040, 32'h5555_AAAA, 4'hF, 0, 0, early);
        wait_b(lat);
        do_read(32'h8000_0040, lat, seen);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_bvalid", 32'(bvalid), 32'd0);
        check("mid_rst_rdata",  rdata,       32'd0);
        exp_b.delete();
        exp_r.delete();
        tick();
        tick();
        rst = 1'b0;
        bready = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {29'd0, awready, wready, arready}, 32'd7);
        check("post_rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        tick();
        do_read(32'h8000_0040, lat, seen);
        check("ram_survives_rst", seen, 32'h5555_AAAA);

        repeat (3) tick();
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);
        check("r_queue_drained", 32'(exp_r.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_ram.md
Name: axi_lite_ram

Overview:
AXI4-Lite target (responder) RAM that terminates the core's data-port AXI initiator (the axi_i_* bus) inside the TCM top or a test harness. It gives the external data port a single-cycle-class memory with independent AW/W acceptance, write-over-read arbitration on a single-port array, and decode errors outside its window. The block is the far end of the dport AXI master, so its port set mirrors that master exactly: no IDs, no bursts.

Parameters:
MEM_BASE, 32'h80000000, byte base address of the decoded window.
MEM_SIZE, 64*1024, window size in bytes; a power of two, at least 4.
READ_WAIT, 2, extra read wait cycles; honoured only with AXI_LITE_RAM_WAIT_EN.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
axi_awvalid_i  in  1  write address valid
axi_awaddr_i  in  32  write byte address
axi_awready_o  out  1  write address accept
axi_wvalid_i  in  1  write data valid
axi_wdata_i  in  32  write data
axi_wstrb_i  in  4  byte strobes
axi_wready_o  out  1  write data accept
axi_bvalid_o  out  1  write response valid
axi_bresp_o  out  2  write response code
axi_bready_i  in  1  write response accept
axi_arvalid_i  in  1  read address valid
axi_araddr_i  in  32  read byte address
axi_arready_o  out  1  read address accept
axi_rvalid_o  out  1  read data valid
axi_rdata_o  out  32  read data
axi_rresp_o  out  2  read response code
axi_rready_i  in  1  read data accept

Behaviour:
- Reset: every output register clears (bvalid, rvalid, bresp, rresp, rdata all 0). Hold registers and the read FSM clear.
  - Once out of reset, awready_o=1, wready_o=1 and arready_o=1.
  - RAM contents are not reset.
  - A reset mid-transaction discards pending AW/W/AR state; no response is issued for it.
- Decode: hit when MEM_BASE <= addr < MEM_BASE+MEM_SIZE.
  - Word index is (addr-MEM_BASE)>>2; addr[1:0] is ignored.
  - A miss gives resp 2'b11 (DECERR). A missed write leaves the RAM unchanged; a missed read returns rdata 0.
- Write path:
  - 1-deep AW hold register and 1-deep W hold register. awready_o = !aw_held_q; wready_o = !w_held_q; both are driven from registers only.
  - Commit happens in a cycle where aw_held_q && w_held_q && (!bvalid_o || bready_i).
  - On commit: byte-enabled RAM write per wstrb (wstrb=0 writes nothing, still OKAY), both holds clear, and bvalid_o rises the next cycle with bresp.
  - Latency: AW and W handshaked in cycle N -> commit at N+1 -> bvalid_o at N+2.
  - AW and W may arrive in any order and with any gap.
  - bvalid_o and bresp stay stable until bready_i.
- Read FSM:
  - States: IDLE, WAIT (only with the macro), RESP.
  - arready_o = (state==IDLE) && !(aw_held_q && w_held_q). The write-commit condition blocks read acceptance, so a write always beats a read for the single RAM port.
  - IDLE + AR handshake at N: RAM read, then -> RESP. rvalid_o is 1 at N+1, with rdata_o and rresp registered.
  - RESP + rready_i -> IDLE. There is no back-to-back AR acceptance in the same cycle as the R handshake; maximum read throughput is 1 per 2 cycles.
  - rdata_o and rresp are stable while rvalid_o && !rready_i. A write commit never alters the registered rdata_o.
- Simultaneous events:
  - AW/W holds full and AR valid: the write commits first and AR waits.
  - bvalid stalled with a new AW+W held: no commit until bready_i, at which point commit and B handshake occur in the same cycle.
  - Read and write responses are independent channels with no ordering between them.

Optional Feature:
AXI_LITE_RAM_WAIT_EN.
- Defined: AR handshake -> WAIT, with a counter loaded to READ_WAIT; the state decrements to 0, then -> RESP.
  - rvalid_o appears READ_WAIT+1 cycles after the AR handshake.
  - READ_WAIT=0 behaves as if the macro were not defined.
  - arready_o is 0 throughout WAIT.
- Undefined: there is no WAIT state and no counter, READ_WAIT is ignored, and the read latency is 1.

Decomposition:
- Package axi_lite_ram_pkg holds:
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the read FSM state encoding;
  - the word-index width function clog2(MEM_SIZE/4).
- One sub-module, axi_lite_ram_mem: single-port, byte-enabled, (MEM_SIZE/4)x32 array with a registered read-data output. That output updates only on a read enable.

Test Plan:
- Write then read: AW and W in the same cycle, addr 0x80000010, data 0xDEADBEEF, wstrb 4'hF -> bvalid at +2 with bresp 0. A following read of 0x80000010 -> rvalid at +1 with rdata 0xDEADBEEF and rresp 0.
- Order and strobes: W first (data 0x11223344, wstrb 4'b0101), AW 3 cycles later to 0x80000010 -> no bvalid before AW is held. A readback gives 0xDE22BE44.
- Out of window: write to 0x7FFFFFFC and read of 0x90000000 -> bresp 2'b11 and rresp 2'b11 with rdata 0. The RAM is unchanged (sampled at 0x80000000).
- Backpressure: bready low for 5 cycles while a second AW+W is held -> bvalid and bresp stable, awready/wready 0 and arready 0, and the second commit happens in the bready cycle. With rready low for 4 cycles, rdata stays stable.
- Conflict plus reset: AW, W and AR all valid in the same cycle -> the write commits first and AR is accepted the cycle after, returning the new data. Asserting rst_i while rvalid is 1 -> rvalid and bvalid drop immediately and all readies are 1 after release.
- With AXI_LITE_RAM_WAIT_EN and READ_WAIT=2: AR at N -> rvalid at N+3 and arready 0 during N+1..N+3. Without the macro: rvalid at N+1.
